// File: rtl/msi_irq_arbiter.sv
// Edge-detecting interrupt collector that turns level sources into round-robin MSI requests,
// one outstanding request at a time, with a fixed idle holdoff after every grant.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for an enabled, unmasked pending source
// REQ   | msi_request/msi_vector held until the core grants
// HOLD  | holdoff down-counter running, no request allowed
module msi_irq_arbiter #(
    parameter int N_SRC   = 4,
    parameter int HOLDOFF = 4
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic [N_SRC-1:0] irq_i,
    input  logic [N_SRC-1:0] irq_mask_i,
    input  logic             msi_enabled,
    input  logic             msi_grant,
    output logic             msi_request,
    output logic [2:0]       msi_vector,
    output logic [N_SRC-1:0] pending_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam logic [2:0] LAST_RST  = 3'(N_SRC - 1);
    localparam logic [7:0] HOLD_LOAD = 8'(HOLDOFF - 1);

    state_t           state;
    state_t           state_nxt;
    logic [N_SRC-1:0] irq_p;
    logic [N_SRC-1:0] pending;
    logic [N_SRC-1:0] pending_nxt;
    logic [N_SRC-1:0] edges;
    logic [N_SRC-1:0] eligible;
    logic [N_SRC-1:0] clr;
    logic [7:0]       cnt;
    logic [7:0]       cnt_nxt;
    logic [2:0]       last_served;
    logic [2:0]       last_nxt;
    logic [2:0]       vec_nxt;
    logic [2:0]       sel_idx;
    logic             sel_valid;
    logic             req_nxt;

    assign edges     = irq_i & ~irq_p;
    assign eligible  = pending & ~irq_mask_i;
    assign pending_o = pending;

    // Round-robin: first eligible source strictly after last_served, wrapping.
    always_comb begin
        int idx;
        sel_valid = 1'b0;
        sel_idx   = '0;
        idx       = 0;
        for (int k = 1; k <= N_SRC; k++) begin
            idx = int'(last_served) + k;
            if (idx >= N_SRC) begin
                idx = idx - N_SRC;
            end
            if (!sel_valid && eligible[idx]) begin
                sel_valid = 1'b1;
                sel_idx   = 3'(idx);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        last_nxt  = last_served;
        req_nxt   = msi_request;
        vec_nxt   = msi_vector;
        clr       = '0;
        case (state)
            ST_IDLE: begin
                if (msi_enabled && sel_valid) begin
                    req_nxt   = 1'b1;
                    vec_nxt   = sel_idx;
                    clr       = {{(N_SRC-1){1'b0}}, 1'b1} << sel_idx;
                    state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (msi_grant) begin
                    req_nxt   = 1'b0;
                    last_nxt  = msi_vector;
                    cnt_nxt   = HOLD_LOAD;
                    state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (cnt == 8'd0) begin
                    state_nxt = ST_IDLE;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
        // A new edge on the source being issued survives the clear.
        pending_nxt = (pending & ~clr) | edges;
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state       <= ST_IDLE;
            irq_p       <= '0;
            pending     <= '0;
            cnt         <= '0;
            last_served <= LAST_RST;
            msi_request <= 1'b0;
            msi_vector  <= '0;
        end else begin
            state       <= state_nxt;
            irq_p       <= irq_i;
            pending     <= pending_nxt;
            cnt         <= cnt_nxt;
            last_served <= last_nxt;
            msi_request <= req_nxt;
            msi_vector  <= vec_nxt;
        end
    end

endmodule

// File: tb/tb_msi_irq_arbiter.sv
// Bench for msi_irq_arbiter: directed scenarios with literal expectations, then randomized
// traffic, all compared every cycle against a behavioural model of the arbiter.
module tb_msi_irq_arbiter;

    localparam int N  = 4;
    localparam int HO = 4;

    logic         aclk = 1'b0;
    logic         aresetn;
    logic [N-1:0] irq_i;
    logic [N-1:0] irq_mask_i;
    logic         msi_enabled;
    logic         msi_grant;
    logic         msi_request;
    logic [2:0]   msi_vector;
    logic [N-1:0] pending_o;

    always #5 aclk = ~aclk;

    msi_irq_arbiter #(.N_SRC(N), .HOLDOFF(HO)) dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .irq_i       (irq_i),
        .irq_mask_i  (irq_mask_i),
        .msi_enabled (msi_enabled),
        .msi_grant   (msi_grant),
        .msi_request (msi_request),
        .msi_vector  (msi_vector),
        .pending_o   (pending_o)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Model: one outstanding request, a count of idle cycles still owed, a pending set.
    bit           m_req;
    int           m_vec;
    bit [N-1:0]   m_pend;
    bit [N-1:0]   m_prev;
    int           m_last;
    int           m_hold;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic void model_step();
        bit [N-1:0] edges;
        bit [N-1:0] clr;
        int         idx;
        if (!aresetn) begin
            m_req  = 0;
            m_vec  = 0;
            m_pend = '0;
            m_prev = '0;
            m_last = N - 1;
            m_hold = 0;
            return;
        end
        edges  = irq_i & ~m_prev;
        m_prev = irq_i;
        clr    = '0;
        if (m_req) begin
            if (msi_grant) begin
                m_last = m_vec;
                m_req  = 0;
                m_hold = HO;
            end
        end else if (m_hold > 0) begin
            m_hold--;
        end else if (msi_enabled) begin
            for (int k = 1; k <= N; k++) begin
                idx = (m_last + k) % N;
                if (m_pend[idx] && !irq_mask_i[idx]) begin
                    m_req    = 1;
                    m_vec    = idx;
                    clr[idx] = 1'b1;
                    break;
                end
            end
        end
        m_pend = (m_pend & ~clr) | edges;
    endfunction

    task automatic tick();
        model_step();
        @(posedge aclk);
        @(negedge aclk);
        check("request", 32'(msi_request), 32'(m_req));
        if (m_req) check("vector", 32'(msi_vector), 32'(m_vec));
        check("pending", 32'(pending_o), 32'(m_pend));
    endtask

    task automatic pulse_grant();
        msi_grant = 1'b1;
        tick();
        msi_grant = 1'b0;
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        tick();
        tick();
        aresetn = 1'b1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_req(input int exp_vec, input string name);
        int n;
        n = 0;
        while (msi_request !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check({name, "_req"}, 32'(msi_request), 32'd1);
        check({name, "_vec"}, 32'(msi_vector), 32'(exp_vec));
    endtask

    initial begin
        aresetn     = 1'b0;
        irq_i       = '0;
        irq_mask_i  = '0;
        msi_enabled = 1'b1;
        msi_grant   = 1'b0;

        // Single edge: pending at cycle 1, request at cycle 2, holdoff of HO cycles.
        do_reset();
        check("rst_req", 32'(msi_request), 32'd0);
        check("rst_vec", 32'(msi_vector), 32'd0);
        check("rst_pend", 32'(pending_o), 32'd0);
        irq_i = 4'b0001;
        tick();
        check("single_pend", 32'(pending_o), 32'b0001);
        check("single_nolat", 32'(msi_request), 32'd0);
        tick();
        check("single_req", 32'(msi_request), 32'd1);
        check("single_vec", 32'(msi_vector), 32'd0);
        check("single_clr", 32'(pending_o), 32'd0);
        ticks(3);
        check("single_hold_req", 32'(msi_request), 32'd1);
        pulse_grant();
        check("single_drop", 32'(msi_request), 32'd0);
        tick();
        irq_i = 4'b0011;
        tick();
        check("hold_pend", 32'(pending_o), 32'b0010);
        ticks(2);
        check("holdoff_idle", 32'(msi_request), 32'd0);
        tick();
        check("after_hold_req", 32'(msi_request), 32'd1);
        check("after_hold_vec", 32'(msi_vector), 32'd1);
        pulse_grant();
        irq_i = '0;
        ticks(HO + 2);

        // Simultaneous rise: served 0,1,2,3, then a new burst starts at 0.
        do_reset();
        irq_i = 4'b1111;
        for (int v = 0; v < N; v++) begin
            wait_req(v, "burst");
            pulse_grant();
        end
        irq_i = '0;
        ticks(HO + 2);
        irq_i = 4'b1111;
        wait_req(0, "burst2");
        pulse_grant();
        irq_i = '0;
        ticks(HO * N + 20);

        // Disabled: edge latched but not issued until enabled.
        do_reset();
        msi_enabled = 1'b0;
        irq_i = 4'b0100;
        ticks(3);
        check("dis_req", 32'(msi_request), 32'd0);
        check("dis_pend", 32'(pending_o), 32'b0100);
        msi_enabled = 1'b1;
        tick();
        check("en_req", 32'(msi_request), 32'd1);
        check("en_vec", 32'(msi_vector), 32'd2);
        pulse_grant();
        irq_i = '0;
        ticks(HO + 2);

        // Mask: masked source 1 waits while source 3 is served.
        do_reset();
        irq_mask_i = 4'b0010;
        irq_i = 4'b1010;
        wait_req(3, "mask");
        check("mask_pend", 32'(pending_o), 32'b0010);
        pulse_grant();
        ticks(HO + 1);
        check("mask_wait", 32'(msi_request), 32'd0);
        irq_mask_i = '0;
        wait_req(1, "unmask");
        pulse_grant();
        irq_i = '0;
        ticks(HO + 2);

        // Re-edge on the source in REQ yields a second request.
        do_reset();
        irq_i = 4'b0001;
        wait_req(0, "redge1");
        irq_i = 4'b0000;
        tick();
        irq_i = 4'b0001;
        tick();
        check("redge_pend", 32'(pending_o), 32'b0001);
        check("redge_vec", 32'(msi_vector), 32'd0);
        pulse_grant();
        wait_req(0, "redge2");
        pulse_grant();
        irq_i = '0;
        ticks(HO + 2);

        // Reset during REQ drops the request; a stray grant afterwards does nothing.
        do_reset();
        irq_i = 4'b0100;
        wait_req(2, "rstreq");
        aresetn = 1'b0;
        irq_i = '0;
        tick();
        check("rstreq_drop", 32'(msi_request), 32'd0);
        check("rstreq_vec", 32'(msi_vector), 32'd0);
        aresetn = 1'b1;
        pulse_grant();
        tick();
        check("stray_req", 32'(msi_request), 32'd0);
        check("stray_pend", 32'(pending_o), 32'd0);

        // Level already high at reset release produces an edge.
        aresetn = 1'b0;
        irq_i = 4'b0100;
        tick();
        aresetn = 1'b1;
        tick();
        check("relhigh_pend", 32'(pending_o), 32'b0100);
        wait_req(2, "relhigh");
        pulse_grant();

        // Randomized traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 7) == 0) irq_i[b] = ~irq_i[b];
            end
            if ($urandom_range(0, 15) == 0) irq_mask_i = N'($urandom);
            if ($urandom_range(0, 19) == 0) msi_enabled = ($urandom_range(0, 9) != 0);
            msi_grant = ($urandom_range(0, 3) == 0);
            aresetn   = ($urandom_range(0, 299) != 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
